// File: rtl/ntsc_pkg.sv
// ============================================================================
//  Module      : ntsc_pkg
//  Description : Shared definitions for the NTSC VRAM arbiter: FSM state
//                encoding, black-level pixel constants and the byte-lane
//                layout of a packed 4:2:2 pixel-pair word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntsc_pkg;

    // Arbiter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE     = 2'd0;
    localparam state_t c_ST_VID_WAIT = 2'd1;
    localparam state_t c_ST_CPU_WAIT = 2'd2;

    // Black level: zero luma, mid-scale chroma
    localparam logic [7:0] c_BLACK_Y = 8'h00;
    localparam logic [7:0] c_BLACK_C = 8'h80;

    // Pair word layout: [31:24] Y0, [23:16] Y1, [15:8] U, [7:0] V
    localparam int c_Y0_LSB = 24;
    localparam int c_Y1_LSB = 16;
    localparam int c_U_LSB  = 8;
    localparam int c_V_LSB  = 0;

    function automatic logic [7:0] byte_at(input logic [31:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

    // Even columns take Y0, odd columns take Y1
    function automatic logic [7:0] pick_luma(input logic [31:0] word, input logic odd);
        return odd ? byte_at(word, c_Y1_LSB) : byte_at(word, c_Y0_LSB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntsc_pair_addr.sv
// ============================================================================
//  Module      : ntsc_pair_addr
//  Description : Pixel-pair VRAM word address generator and visible-area
//                range check. The row base is built from shifted copies of
//                the row number, one per set bit of LINE_WORDS, so only
//                adders are used.
//  Ports       : i_pos_y     - pixel row
//                i_pair_col  - pixel column / 2 (pair index in the row)
//                o_addr      - row*LINE_WORDS + pair index, mod 2^ADDR_W
//                o_in_range  - 1 when the position lies in the displayed area
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntsc_pair_addr #(
    parameter int LINE_WORDS = 320,
    parameter int NUM_LINES  = 200,
    parameter int ADDR_W     = 16
) (
    input  logic [9:0]        i_pos_y,
    input  logic [8:0]        i_pair_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);

    localparam logic [31:0] c_LINE_VEC  = LINE_WORDS;
    localparam logic [31:0] c_LINES_VEC = NUM_LINES;

    logic [ADDR_W-1:0] w_row_base;

    // Sum of (row << b) for every set bit b of the line width; truncation
    // to ADDR_W at each step matches truncating the full product.
    always_comb begin
        w_row_base = '0;
        for (int b = 0; b < 32; b++) begin
            if (c_LINE_VEC[b]) begin
                w_row_base = w_row_base + (ADDR_W'(i_pos_y) << b);
            end
        end
    end

    assign o_addr     = w_row_base + ADDR_W'(i_pair_col);
    assign o_in_range = ({22'd0, i_pos_y} < c_LINES_VEC) &&
                        ({23'd0, i_pair_col} < c_LINE_VEC);

endmodule

`default_nettype wire

// File: rtl/ntsc_vram_arb.sv
// ============================================================================
//  Module      : ntsc_vram_arb
//  Description : Shared VRAM arbiter and pixel fetch controller. Video pair
//                fetches have priority; leftover slots serve one CPU port.
//                A one-word pair cache avoids refetching within a pair.
//  Ports       : clock/reset          - clock, synchronous active-high reset
//                pixPosX/pixPosY      - encoder scan position
//                pixCy/pixCu/pixCv    - registered pixel colour
//                cpuReq/We/Addr/WData - CPU request, held until cpuAck
//                cpuRData/cpuAck      - CPU completion pulse and read data
//                vramEn/We/Addr/WData - registered VRAM command
//                vramRData            - VRAM read data, one cycle after vramEn
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntsc_vram_arb
    import ntsc_pkg::*;
#(
    parameter int LINE_WORDS = 320,
    parameter int NUM_LINES  = 200,
    parameter int ADDR_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        pixPosX,
    input  logic [9:0]        pixPosY,
    output logic [7:0]        pixCy,
    output logic [7:0]        pixCu,
    output logic [7:0]        pixCv,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [31:0]       cpuWData,
    output logic [31:0]       cpuRData,
    output logic              cpuAck,
    output logic              vramEn,
    output logic              vramWe,
    output logic [ADDR_W-1:0] vramAddr,
    output logic [31:0]       vramWData,
    input  logic [31:0]       vramRData
);

    state_t            r_state;
    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [31:0]       r_pair;
    logic              r_vid_pend;   // video read data arrives this cycle
    logic              r_cpu_pend;   // CPU access completes this cycle
    logic              r_cpu_rd;
    logic              r_vram_en;
    logic              r_vram_we;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [31:0]       r_vram_wdata;
    logic [7:0]        r_cy;
    logic [7:0]        r_cu;
    logic [7:0]        r_cv;

    logic [ADDR_W-1:0] w_addr;
    logic              w_in_range;
    logic              w_hit;
    logic              w_byp;
    logic              w_miss;
    logic              w_wr_hit;

    ntsc_pair_addr #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .ADDR_W     (ADDR_W)
    ) u_pair_addr (
        .i_pos_y    (pixPosY),
        .i_pair_col (pixPosX[9:1]),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

    // VRAM read data lands in the cycle after the wait state, overlapping
    // the next IDLE cycle. r_vram_addr still holds the fetched address then,
    // so a landing fetch of the current pair counts as a hit (w_byp) and its
    // data is forwarded straight to the pixel registers.
    assign w_hit  = r_valid && (r_tag == w_addr);
    assign w_byp  = r_vid_pend && (r_vram_addr == w_addr);
    assign w_miss = w_in_range && !w_hit && !w_byp;

    // A CPU write to the cached pair (or to the pair being captured now)
    // invalidates it so the following IDLE cycle refetches.
    assign w_wr_hit = cpuWe && ((cpuAddr == r_tag) ||
                                (r_vid_pend && (cpuAddr == r_vram_addr)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_valid      <= 1'b0;
            r_tag        <= '0;
            r_pair       <= '0;
            r_vid_pend   <= 1'b0;
            r_cpu_pend   <= 1'b0;
            r_cpu_rd     <= 1'b0;
            r_vram_en    <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
        end else begin
            r_vram_en  <= 1'b0;
            r_vram_we  <= 1'b0;
            r_vid_pend <= 1'b0;
            r_cpu_pend <= 1'b0;

            if (r_vid_pend) begin
                r_pair  <= vramRData;
                r_tag   <= r_vram_addr;
                r_valid <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss) begin
                        r_vram_en   <= 1'b1;
                        r_vram_addr <= w_addr;
                        r_state     <= c_ST_VID_WAIT;
                    end else if (cpuReq && !r_cpu_pend) begin
                        // r_cpu_pend blocks re-issuing the request that is
                        // being acknowledged this very cycle.
                        r_vram_en    <= 1'b1;
                        r_vram_we    <= cpuWe;
                        r_vram_addr  <= cpuAddr;
                        r_vram_wdata <= cpuWData;
                        r_cpu_rd     <= !cpuWe;
                        r_state      <= c_ST_CPU_WAIT;
                        if (w_wr_hit) begin
                            r_valid <= 1'b0;
                        end
                    end
                end
                c_ST_VID_WAIT: begin
                    r_vid_pend <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
                c_ST_CPU_WAIT: begin
                    r_cpu_pend <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Pixel outputs: black outside the display, fresh data on a hit,
    // otherwise hold until the pending fetch lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cy <= c_BLACK_Y;
            r_cu <= c_BLACK_C;
            r_cv <= c_BLACK_C;
        end else if (!w_in_range) begin
            r_cy <= c_BLACK_Y;
            r_cu <= c_BLACK_C;
            r_cv <= c_BLACK_C;
        end else if (w_byp) begin
            r_cy <= pick_luma(vramRData, pixPosX[0]);
            r_cu <= byte_at(vramRData, c_U_LSB);
            r_cv <= byte_at(vramRData, c_V_LSB);
        end else if (w_hit) begin
            r_cy <= pick_luma(r_pair, pixPosX[0]);
            r_cu <= byte_at(r_pair, c_U_LSB);
            r_cv <= byte_at(r_pair, c_V_LSB);
        end
    end

    assign pixCy     = r_cy;
    assign pixCu     = r_cu;
    assign pixCv     = r_cv;
    assign cpuAck    = r_cpu_pend;
    assign cpuRData  = (r_cpu_pend && r_cpu_rd) ? vramRData : 32'd0;
    assign vramEn    = r_vram_en;
    assign vramWe    = r_vram_we;
    assign vramAddr  = r_vram_addr;
    assign vramWData = r_vram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ntsc_vram_arb.sv
// ============================================================================
//  Module      : tb_ntsc_vram_arb
//  Description : Directed self-checking bench for ntsc_vram_arb with a
//                behavioural single-port synchronous VRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntsc_vram_arb;

    logic        clock;
    logic        reset;
    logic [9:0]  pixPosX;
    logic [9:0]  pixPosY;
    logic [7:0]  pixCy;
    logic [7:0]  pixCu;
    logic [7:0]  pixCv;
    logic        cpuReq;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [31:0] cpuWData;
    logic [31:0] cpuRData;
    logic        cpuAck;
    logic        vramEn;
    logic        vramWe;
    logic [15:0] vramAddr;
    logic [31:0] vramWData;
    logic [31:0] vramRData;

    logic [31:0] mem [0:65535];
    int          en_cnt;
    logic [15:0] last_rd;
    int          n_checks;
    int          n_fail;
    int          base;

    ntsc_vram_arb #(
        .LINE_WORDS (320),
        .NUM_LINES  (200),
        .ADDR_W     (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pixPosX   (pixPosX),
        .pixPosY   (pixPosY),
        .pixCy     (pixCy),
        .pixCu     (pixCu),
        .pixCv     (pixCv),
        .cpuReq    (cpuReq),
        .cpuWe     (cpuWe),
        .cpuAddr   (cpuAddr),
        .cpuWData  (cpuWData),
        .cpuRData  (cpuRData),
        .cpuAck    (cpuAck),
        .vramEn    (vramEn),
        .vramWe    (vramWe),
        .vramAddr  (vramAddr),
        .vramWData (vramWData),
        .vramRData (vramRData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port VRAM plus access bookkeeping
    always @(posedge clock) begin
        if (vramEn) begin
            en_cnt <= en_cnt + 1;
            if (vramWe) begin
                mem[vramAddr] <= vramWData;
            end else begin
                vramRData <= mem[vramAddr];
                last_rd   <= vramAddr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        en_cnt    = 0;
        last_rd   = '0;
        vramRData = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[0]   = 32'h10205A60;
        mem[1]   = 32'h30405060;
        mem[7]   = 32'h0BADF00D;
        mem[322] = 32'hA1B2C3D4;

        reset    = 1'b1;
        pixPosX  = 10'd0;
        pixPosY  = 10'd300;
        cpuReq   = 1'b0;
        cpuWe    = 1'b0;
        cpuAddr  = '0;
        cpuWData = '0;

        // Reset state
        repeat (3) tick();
        neg(1);
        check("rst_cy",    {24'd0, pixCy}, 32'h00);
        check("rst_cu",    {24'd0, pixCu}, 32'h80);
        check("rst_cv",    {24'd0, pixCv}, 32'h80);
        check("rst_en",    {31'd0, vramEn}, 32'd0);
        check("rst_ack",   {31'd0, cpuAck}, 32'd0);
        check("rst_addr",  {16'd0, vramAddr}, 32'd0);
        check("rst_rdata", cpuRData, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Fetch of pair 0 at (0,0)
        pixPosX = 10'd0; pixPosY = 10'd0;
        neg(1);
        check("p0_en_t0",  {31'd0, vramEn}, 32'd0);
        neg(1);
        check("p0_en_t1",  {31'd0, vramEn}, 32'd1);
        check("p0_addr",   {16'd0, vramAddr}, 32'd0);
        neg(2);
        check("p0_cy",     {24'd0, pixCy}, 32'h10);
        check("p0_cu",     {24'd0, pixCu}, 32'h5A);
        check("p0_cv",     {24'd0, pixCv}, 32'h60);

        // X=1 reuses the cached pair
        tick();
        base = en_cnt;
        pixPosX = 10'd1;
        neg(3);
        check("x1_cy",     {24'd0, pixCy}, 32'h20);
        check("x1_nofetch", en_cnt, base);

        // (4,1) -> pair address 322
        tick();
        pixPosX = 10'd4; pixPosY = 10'd1;
        neg(2);
        check("p322_en",   {31'd0, vramEn}, 32'd1);
        check("p322_addr", {16'd0, vramAddr}, 32'd322);
        neg(2);
        check("p322_cy",   {24'd0, pixCy}, 32'hA1);
        check("p322_cu",   {24'd0, pixCu}, 32'hC3);
        check("p322_cv",   {24'd0, pixCv}, 32'hD4);

        // Y=200 is below the display
        tick();
        base = en_cnt;
        pixPosX = 10'd0; pixPosY = 10'd200;
        neg(3);
        check("y200_nofetch", en_cnt, base);
        check("y200_cy",   {24'd0, pixCy}, 32'h00);
        check("y200_cu",   {24'd0, pixCu}, 32'h80);
        check("y200_cv",   {24'd0, pixCv}, 32'h80);

        // X=640 is right of the display
        tick();
        base = en_cnt;
        pixPosX = 10'd640; pixPosY = 10'd0;
        neg(3);
        check("x640_nofetch", en_cnt, base);
        check("x640_cy",   {24'd0, pixCy}, 32'h00);
        check("x640_cu",   {24'd0, pixCu}, 32'h80);
        check("x640_cv",   {24'd0, pixCv}, 32'h80);

        // Video miss and CPU read in the same IDLE cycle
        tick();
        pixPosX = 10'd0; pixPosY = 10'd0;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'd7;
        neg(2);
        check("tie_vid_en",   {31'd0, vramEn}, 32'd1);
        check("tie_vid_addr", {16'd0, vramAddr}, 32'd0);
        check("tie_vid_we",   {31'd0, vramWe}, 32'd0);
        neg(1);
        check("tie_gap_en",   {31'd0, vramEn}, 32'd0);
        neg(1);
        check("tie_cpu_en",   {31'd0, vramEn}, 32'd1);
        check("tie_cpu_addr", {16'd0, vramAddr}, 32'd7);
        check("tie_ack_early", {31'd0, cpuAck}, 32'd0);
        neg(1);
        check("tie_ack",      {31'd0, cpuAck}, 32'd1);
        check("tie_rdata",    cpuRData, 32'h0BADF00D);
        check("tie_cy",       {24'd0, pixCy}, 32'h10);
        tick();
        cpuReq = 1'b0;

        // Cache (2,0) -> pair 1
        pixPosX = 10'd2;
        neg(4);
        check("p1_cy",     {24'd0, pixCy}, 32'h30);
        check("p1_cu",     {24'd0, pixCu}, 32'h50);

        // CPU write to the cached pair forces a refetch
        tick();
        base = en_cnt;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'd1; cpuWData = 32'hFF000000;
        neg(1);
        check("wr1_ack_t0", {31'd0, cpuAck}, 32'd0);
        neg(1);
        check("wr1_we",    {31'd0, vramWe}, 32'd1);
        check("wr1_wdata", vramWData, 32'hFF000000);
        neg(1);
        check("wr1_ack",   {31'd0, cpuAck}, 32'd1);
        check("wr1_rdata", cpuRData, 32'd0);
        tick();
        cpuReq = 1'b0;
        neg(4);
        check("wr1_cy",      {24'd0, pixCy}, 32'hFF);
        check("wr1_cu",      {24'd0, pixCu}, 32'h00);
        check("wr1_accesses", en_cnt, base + 2);
        check("wr1_refetch", {16'd0, last_rd}, 32'd1);

        // CPU write elsewhere leaves the cache alone
        tick();
        base = en_cnt;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'd5; cpuWData = 32'h12345678;
        neg(3);
        check("wr5_ack",   {31'd0, cpuAck}, 32'd1);
        tick();
        cpuReq = 1'b0;
        neg(6);
        check("wr5_accesses", en_cnt, base + 1);
        check("wr5_cy",    {24'd0, pixCy}, 32'hFF);

        // Reset while a CPU read is in CPU_WAIT
        tick();
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'd7;
        tick();
        reset = 1'b1;
        cpuReq = 1'b0;
        neg(1);
        check("mid_en",    {31'd0, vramEn}, 32'd1);
        check("mid_addr",  {16'd0, vramAddr}, 32'd7);
        neg(1);
        check("mrst_ack",   {31'd0, cpuAck}, 32'd0);
        check("mrst_rdata", cpuRData, 32'd0);
        check("mrst_en",    {31'd0, vramEn}, 32'd0);
        check("mrst_addr",  {16'd0, vramAddr}, 32'd0);
        check("mrst_wdata", vramWData, 32'd0);
        check("mrst_cy",    {24'd0, pixCy}, 32'h00);
        check("mrst_cu",    {24'd0, pixCu}, 32'h80);
        check("mrst_cv",    {24'd0, pixCv}, 32'h80);
        tick();
        reset = 1'b0;
        neg(1);
        check("post_ack",  {31'd0, cpuAck}, 32'd0);
        neg(1);
        check("post_en",   {31'd0, vramEn}, 32'd1);
        check("post_addr", {16'd0, vramAddr}, 32'd1);
        neg(2);
        check("post_cy",   {24'd0, pixCy}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
